// File: rtl/tcm_port_arbiter.sv
// Two-master arbiter onto one single-port TCM SRAM, with atomic lock.
// Define TCM_ARB_RR_EN for round-robin on collisions (fixed m0 priority otherwise).
module tcm_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRW      = 10,
  localparam int BEW       = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  m0_req_i,
  input  logic                  m0_we_i,
  input  logic [BEW-1:0]        m0_be_i,
  input  logic [ADDRW-1:0]      m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  input  logic                  m0_lock_i,
  output logic                  m0_gnt_o,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic                  m0_rvalid_o,
  input  logic                  m1_req_i,
  input  logic                  m1_we_i,
  input  logic [BEW-1:0]        m1_be_i,
  input  logic [ADDRW-1:0]      m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  input  logic                  m1_lock_i,
  output logic                  m1_gnt_o,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  m1_rvalid_o,
  output logic                  sram_en_o,
  output logic                  sram_we_o,
  output logic [BEW-1:0]        sram_be_o,
  output logic [ADDRW-1:0]      sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_data_o,
  input  logic [DATA_WIDTH-1:0] sram_data_i,
  input  logic                  sram_ready_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } lock_e;

  lock_e state;
  logic  last;
  logic  owner;
  logic  owner_vld;
  logic  win1;
  logic  g0;
  logic  g1;

`ifdef TCM_ARB_RR_EN
  assign win1 = ~last;
`else
  // Pointer is still tracked, but fixed priority never consults it.
  assign win1 = 1'b0 & ~last;
`endif

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst_ni) begin
      unique case (state)
        IDLE: begin
          g0 = m0_req_i & ~(m1_req_i & win1);
          g1 = m1_req_i & (~m0_req_i | win1);
        end
        LOCK0: g0 = m0_req_i;
        LOCK1: g1 = m1_req_i;
        default: ;
      endcase
    end
  end

  assign m0_gnt_o    = g0;
  assign m1_gnt_o    = g1;
  assign sram_en_o   = g0 | g1;
  assign sram_we_o   = (g0 & m0_we_i) | (g1 & m1_we_i);
  assign sram_be_o   = g1 ? m1_be_i : (g0 ? m0_be_i : '0);
  assign sram_addr_o = g1 ? m1_addr_i : m0_addr_i;
  assign sram_data_o = g1 ? m1_data_i : m0_data_i;

  assign m0_rvalid_o = sram_ready_i & owner_vld & ~owner;
  assign m1_rvalid_o = sram_ready_i & owner_vld & owner;
  assign m0_data_o   = rst_ni ? sram_data_i : '0;
  assign m1_data_o   = rst_ni ? sram_data_i : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      owner_vld <= 1'b0;
    end else begin
      owner_vld <= g0 | g1;
      if (g0 | g1) begin
        owner <= g1;
        last  <= g1;
      end
      unique case (state)
        IDLE: begin
          if (g0 & m0_lock_i)      state <= LOCK0;
          else if (g1 & m1_lock_i) state <= LOCK1;
        end
        LOCK0: if (!m0_req_i || !m0_lock_i) state <= IDLE;
        LOCK1: if (!m1_req_i || !m1_lock_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Directed bench for tcm_port_arbiter: per-cycle vector table
// plus hand sequences for write muxing and reset with a pending response.
module tb_tcm_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [3:0]  m0_be, m1_be;
  logic [9:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        sram_en, sram_we, sram_ready;
  logic [3:0]  sram_be;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata, sram_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tcm_port_arbiter #(.DATA_WIDTH(32), .ADDRW(10)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be),
    .m0_addr_i(m0_addr), .m0_data_i(m0_wdata), .m0_lock_i(m0_lock),
    .m0_gnt_o(m0_gnt), .m0_data_o(m0_rdata), .m0_rvalid_o(m0_rvalid),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be),
    .m1_addr_i(m1_addr), .m1_data_i(m1_wdata), .m1_lock_i(m1_lock),
    .m1_gnt_o(m1_gnt), .m1_data_o(m1_rdata), .m1_rvalid_o(m1_rvalid),
    .sram_en_o(sram_en), .sram_we_o(sram_we), .sram_be_o(sram_be),
    .sram_addr_o(sram_addr), .sram_data_o(sram_wdata),
    .sram_data_i(sram_rdata), .sram_ready_i(sram_ready)
  );

  typedef struct {
    logic        r0, l0, r1, l1, rdy;
    logic [31:0] rdata;
    logic        g0, g1, v0, v1;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r0, l0, r1, l1, rdy,
                     input logic [31:0] rdata,
                     input logic g0, g1, v0, v1);
    vec_t v;
    v.r0 = r0; v.l0 = l0; v.r1 = r1; v.l1 = l1; v.rdy = rdy;
    v.rdata = rdata; v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1; m0_lock = 1'b0; m1_lock = 1'b0;
    m0_we = 1'b0; m1_we = 1'b0; m0_be = 4'hF; m1_be = 4'hF;
    m0_addr = 10'h010; m1_addr = 10'h020;
    m0_wdata = 32'h0; m1_wdata = 32'h0;
    sram_ready = 1'b1; sram_rdata = 32'hFFFF_FFFF;

    // Cycles after reset: collisions, then REQ sequences
`ifdef TCM_ARB_RR_EN
    add(1,0,1,0,0, 32'hA000_0000, 1,0,0,0);
    add(1,0,1,0,1, 32'hA000_0001, 0,1,1,0);
    add(1,0,1,0,1, 32'hA000_0002, 1,0,0,1);
    add(1,0,1,0,1, 32'hA000_0003, 0,1,1,0);
    add(0,0,1,0,1, 32'hA000_0004, 0,1,0,1);
`else
    add(1,0,1,0,0, 32'hA000_0000, 1,0,0,0);
    add(1,0,1,0,1, 32'hA000_0001, 1,0,1,0);
    add(1,0,1,0,1, 32'hA000_0002, 1,0,1,0);
    add(1,0,1,0,1, 32'hA000_0003, 1,0,1,0);
    add(0,0,1,0,1, 32'hA000_0004, 0,1,1,0);
`endif
    add(1,0,0,0,1, 32'hA000_0005, 1,0,0,1);
    add(0,0,0,0,1, 32'hDEAD_BEEF, 0,0,1,0);
    add(0,0,0,0,1, 32'hA000_0007, 0,0,0,0);
    add(0,0,1,1,0, 32'hA000_0008, 0,1,0,0);
    add(1,0,1,1,1, 32'hA000_0009, 0,1,0,1);
    add(1,0,1,1,1, 32'hA000_000A, 0,1,0,1);
    add(1,0,1,0,1, 32'hA000_000B, 0,1,0,1);
    add(1,0,0,0,1, 32'hA000_000C, 1,0,0,1);
    add(1,1,0,0,1, 32'hA000_000D, 1,0,1,0);
    add(1,0,1,0,1, 32'hA000_000E, 1,0,1,0);
    add(1,1,0,0,1, 32'hA000_000F, 1,0,1,0);
    add(0,0,1,0,1, 32'hA000_0010, 0,0,1,0);
    add(0,0,1,0,0, 32'hA000_0011, 0,1,0,0);
    add(0,0,0,0,1, 32'hA000_0012, 0,0,0,1);

    // Reset held with both requesting
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_g0", m0_gnt, 0);
    chk("rst_g1", m1_gnt, 0);
    chk("rst_en", sram_en, 0);
    chk("rst_v0", m0_rvalid, 0);
    chk("rst_v1", m1_rvalid, 0);
    chk("rst_d0", m0_rdata, 0);
    chk("rst_d1", m1_rdata, 0);

    @(negedge clk);
    rst_ni = 1'b1; m0_req = 1'b0; m1_req = 1'b0; sram_ready = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      m0_req = tbl[i].r0; m0_lock = tbl[i].l0;
      m1_req = tbl[i].r1; m1_lock = tbl[i].l1;
      sram_ready = tbl[i].rdy; sram_rdata = tbl[i].rdata;
      #1;
      chk($sformatf("row%0d_g0", i), m0_gnt, tbl[i].g0);
      chk($sformatf("row%0d_g1", i), m1_gnt, tbl[i].g1);
      chk($sformatf("row%0d_v0", i), m0_rvalid, tbl[i].v0);
      chk($sformatf("row%0d_v1", i), m1_rvalid, tbl[i].v1);
      chk($sformatf("row%0d_en", i), sram_en, tbl[i].g0 | tbl[i].g1);
      if (tbl[i].g0)
        chk($sformatf("row%0d_addr", i), sram_addr, 10'h010);
      if (tbl[i].g1)
        chk($sformatf("row%0d_addr", i), sram_addr, 10'h020);
      if (tbl[i].rdy) begin
        chk($sformatf("row%0d_d0", i), m0_rdata, tbl[i].rdata);
        chk($sformatf("row%0d_d1", i), m1_rdata, tbl[i].rdata);
      end
    end

    // Byte-masked write at the top address
    @(negedge clk);
    m0_req = 1'b1; m0_lock = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
    m0_we = 1'b1; m0_be = 4'b0011; m0_addr = 10'h3FF;
    m0_wdata = 32'h1234_5678; sram_ready = 1'b0;
    #1;
    chk("wr_gnt", m0_gnt, 1);
    chk("wr_en", sram_en, 1);
    chk("wr_we", sram_we, 1);
    chk("wr_be", sram_be, 4'b0011);
    chk("wr_addr", sram_addr, 10'h3FF);
    chk("wr_data", sram_wdata, 32'h1234_5678);
    @(negedge clk);
    m0_req = 1'b0; sram_ready = 1'b1;
    #1;
    chk("idle_we", sram_we, 0);
    chk("idle_be", sram_be, 0);
    chk("idle_en", sram_en, 0);
    chk("wr_v0", m0_rvalid, 1);
    chk("wr_v1", m1_rvalid, 0);

    // Reset lands while m1's response is outstanding
    @(negedge clk);
    m0_we = 1'b0; m1_req = 1'b1; sram_ready = 1'b0;
    #1;
    chk("pre_g1", m1_gnt, 1);
    @(negedge clk);
    rst_ni = 1'b0; m0_req = 1'b1; sram_ready = 1'b1;
    sram_rdata = 32'h5555_AAAA;
    #1;
    chk("mid_g0", m0_gnt, 0);
    chk("mid_g1", m1_gnt, 0);
    chk("mid_en", sram_en, 0);
    chk("mid_v1", m1_rvalid, 0);
    chk("mid_d1", m1_rdata, 0);
    @(negedge clk);
    rst_ni = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
    #1;
    chk("post_v0", m0_rvalid, 0);
    chk("post_v1", m1_rvalid, 0);
    @(negedge clk);
    #1;
    chk("post2_v0", m0_rvalid, 0);
    chk("post2_v1", m1_rvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
